// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-draining UART transmitter.
// FIFO_UART_TX_PARITY_EN adds an even-parity bit and the PARITY state.
package fifo_uart_pkg;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam int   DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef FIFO_UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } uart_state_e;

    // Serial bits per frame: start + data + optional parity + stop.
    function automatic int frame_bits();
`ifdef FIFO_UART_TX_PARITY_EN
        return 1 + DATA_BITS + 1 + 1;
`else
        return 1 + DATA_BITS + 1;
`endif
    endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// Read port of the byte FIFO as seen by its drain-side consumer.
interface fifo_uart_tx_if;
    import fifo_uart_pkg::*;

    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_data;
    logic                 fifo_read_enable;

    // master: the consumer that pops; slave: the FIFO itself.
    modport master (
        input  fifo_empty,
        input  fifo_data,
        output fifo_read_enable
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        input  fifo_read_enable
    );

endinterface

// File: rtl/baud_tick_counter.sv
// Bit-time counter: counts 0..CLKS_PER_BIT-1 and flags the final count.
module baud_tick_counter #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    output logic bit_done
);

    localparam int unsigned       CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]     LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Restart realigns bit boundaries to the pop so the start bit is a full bit time.
    always_comb begin
        count_d = count_q + CW'(1);
        if (restart || (count_q == LAST)) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign bit_done = (count_q == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from a FIFO and sends each as a UART frame (start, 8 data LSB first, stop).
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  tx_enable,
    fifo_uart_tx_if.master        fifo,
    output logic                  tx,
    output logic                  busy,
    output logic [15:0]           frame_count
);

    localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

    uart_state_e          state_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [2:0]           idx_q;
    logic                 tx_q;
    logic                 busy_q;
    logic [15:0]          frame_count_q;
`ifdef FIFO_UART_TX_PARITY_EN
    logic                 parity_q;
`endif

    logic bit_done;
    logic stop_last;
    logic pop;

    baud_tick_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clock    (clock),
        .reset    (reset),
        .restart  (pop),
        .bit_done (bit_done)
    );

    // Popping in the last stop cycle chains frames with no idle gap.
    assign stop_last             = (state_q == ST_STOP) && bit_done;
    assign pop                   = ((state_q == ST_IDLE) || stop_last) && tx_enable
                                   && !fifo.fifo_empty && !reset;
    assign fifo.fifo_read_enable = pop;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            shift_q       <= '0;
            idx_q         <= '0;
            tx_q          <= STOP_BIT;
            busy_q        <= 1'b0;
            frame_count_q <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q      <= 1'b0;
`endif
        end else begin
            if (stop_last) begin
                frame_count_q <= frame_count_q + 16'd1;
            end

            if (pop) begin
                state_q  <= ST_START;
                shift_q  <= fifo.fifo_data;
                idx_q    <= '0;
                tx_q     <= START_BIT;
                busy_q   <= 1'b1;
`ifdef FIFO_UART_TX_PARITY_EN
                parity_q <= ^fifo.fifo_data;
`endif
            end else if (bit_done) begin
                case (state_q)
                    ST_IDLE: begin
                        tx_q   <= STOP_BIT;
                        busy_q <= 1'b0;
                    end
                    ST_START: begin
                        state_q <= ST_DATA;
                        tx_q    <= shift_q[0];
                    end
                    ST_DATA: begin
                        if (idx_q == LAST_IDX) begin
`ifdef FIFO_UART_TX_PARITY_EN
                            state_q <= ST_PARITY;
                            tx_q    <= parity_q;
`else
                            state_q <= ST_STOP;
                            tx_q    <= STOP_BIT;
`endif
                        end else begin
                            idx_q   <= idx_q + 3'd1;
                            shift_q <= shift_q >> 1;
                            tx_q    <= shift_q[1];
                        end
                    end
`ifdef FIFO_UART_TX_PARITY_EN
                    ST_PARITY: begin
                        state_q <= ST_STOP;
                        tx_q    <= STOP_BIT;
                    end
`endif
                    ST_STOP: begin
                        state_q <= ST_IDLE;
                        tx_q    <= STOP_BIT;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        tx_q    <= STOP_BIT;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign tx          = tx_q;
    assign busy        = busy_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: FIFO model, frame scoreboard and monitor.
module tb_fifo_uart_tx;
    import fifo_uart_pkg::*;

    localparam int N     = 4;
    localparam int FRAME = frame_bits();
    localparam int P     = FRAME * N;

    logic        clock;
    logic        reset;
    logic        tx_enable;
    logic        tx;
    logic        busy;
    logic [15:0] frame_count;

    fifo_uart_tx_if bus ();

    fifo_uart_tx #(
        .CLKS_PER_BIT (N)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .tx_enable   (tx_enable),
        .fifo        (bus),
        .tx          (tx),
        .busy        (busy),
        .frame_count (frame_count)
    );

    int         cyc = 0;
    int         pass_cnt = 0;
    int         total_cnt = 0;
    logic [7:0] fq[$];
    logic [7:0] sb[$];
    int         pop_log[$];

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt = total_cnt + 1;
        assert (obs === exp) begin
            pass_cnt = pass_cnt + 1;
        end else begin
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        fq.push_back(b);
        sb.push_back(b);
        $display("push byte %02h at cycle %0d", b, cyc);
    endtask

    task automatic goto_cycle(input int c);
        do begin
            @(negedge clock);
            #1;
        end while (cyc < c);
    endtask

    task automatic drive_at(input int c);
        goto_cycle(c - 1);
        @(posedge clock);
        #2;
    endtask

    task automatic wait_pops(input int n, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (pop_log.size() >= n) break;
            @(negedge clock);
            #1;
        end
        if (pop_log.size() < n) check("pop_timeout", pop_log.size(), n);
    endtask

    // FIFO model: pops sampled mid-cycle, applied after the edge, outputs refreshed later.
    initial begin : fifo_model
        logic rd;
        forever begin
            @(negedge clock);
            rd = bus.fifo_read_enable;
            @(posedge clock);
            #1;
            if (rd && fq.size() > 0) void'(fq.pop_front());
            #2;
            bus.fifo_empty = (fq.size() == 0);
            bus.fifo_data  = (fq.size() == 0) ? 8'h00 : fq[0];
        end
    end

    // Monitor: checks every tx cycle of a frame against the scoreboard byte.
    initial begin : monitor
        int          pos;
        logic [10:0] fv;
        logic [7:0]  b;
        pos = -1;
        fv  = '1;
        forever begin
            @(negedge clock);
            if (reset) begin
                pos = -1;
            end else begin
                if (pos >= 0) begin
                    check("tx_frame", tx, fv[pos / N]);
                    check("busy_frame", busy, 1'b1);
                    pos = pos + 1;
                    if (pos == P) pos = -1;
                end else begin
                    check("tx_idle", tx, 1'b1);
                    check("busy_idle", busy, 1'b0);
                end
                if (bus.fifo_read_enable === 1'b1) begin
                    check("pop_nonempty", bus.fifo_empty, 1'b0);
                    check("pop_single", 32'(pos == -1), 32'd1);
                    pop_log.push_back(cyc);
                    if (sb.size() == 0) begin
                        check("sb_underflow", 32'(sb.size()), 32'd1);
                        b = 8'h00;
                    end else begin
                        b = sb.pop_front();
                    end
                    fv       = '1;
                    fv[0]    = START_BIT;
                    fv[8:1]  = b;
`ifdef FIFO_UART_TX_PARITY_EN
                    fv[9]    = ^b;
`endif
                    pos = 0;
                    $display("pop byte %02h at cycle %0d", b, cyc);
                end
            end
        end
    end

    initial begin : stimulus
        int k;
        int c0;
        int rel;

        // Reset held 3 cycles with data present: no pop, idle outputs.
        reset     = 1'b1;
        tx_enable = 1'b1;
        push(8'hA5);
        repeat (3) begin
            @(negedge clock);
            #1;
            check("rst_rd_en", bus.fifo_read_enable, 1'b0);
            check("rst_tx", tx, 1'b1);
            check("rst_busy", busy, 1'b0);
            check("rst_fcount", frame_count, 16'd0);
        end
        @(posedge clock);
        #2;
        reset = 1'b0;
        rel   = cyc;

        // Single byte 0xA5 popped in the first non-reset cycle.
        wait_pops(1, 20);
        k = pop_log[0];
        check("pop_latency", k, rel);
        goto_cycle(k + P);
        check("stop_last_busy", busy, 1'b1);
        check("stop_last_tx", tx, 1'b1);
        check("stop_last_fcount", frame_count, 16'd0);
        goto_cycle(k + P + 1);
        check("single_busy", busy, 1'b0);
        check("single_fcount", frame_count, 16'd1);
        check("single_pops", pop_log.size(), 1);

        // Three bytes queued: back-to-back frames, exact period.
        @(posedge clock);
        #2;
        c0 = cyc;
        push(8'h07);
        push(8'h3C);
        push(8'h81);
        wait_pops(2, 10);
        check("b2b_first_pop", pop_log[1], c0);
        wait_pops(4, 3 * P);
        check("b2b_period1", pop_log[2] - pop_log[1], P);
        check("b2b_period2", pop_log[3] - pop_log[2], P);
        goto_cycle(pop_log[3] + P + 1);
        check("b2b_fcount", frame_count, 16'd4);
        check("b2b_busy", busy, 1'b0);
        check("b2b_pops", pop_log.size(), 4);

        // tx_enable dropped mid-frame with a second byte waiting.
        @(posedge clock);
        #2;
        push(8'h5A);
        push(8'hC3);
        wait_pops(5, 10);
        k = pop_log[4];
        drive_at(k + 10);
        tx_enable = 1'b0;
        goto_cycle(k + P + 21);
        check("txen_pops", pop_log.size(), 5);
        check("txen_fcount", frame_count, 16'd5);
        check("txen_busy", busy, 1'b0);
        check("txen_pending", bus.fifo_empty, 1'b0);
        @(posedge clock);
        #2;
        tx_enable = 1'b1;
        c0 = cyc;
        wait_pops(6, 10);
        check("txen_resume_pop", pop_log[5], c0);
        goto_cycle(pop_log[5] + P + 1);
        check("txen_resume_fcount", frame_count, 16'd6);

        // Reset pulsed 20 cycles into a frame; the popped byte is abandoned.
        @(posedge clock);
        #2;
        push(8'h99);
        push(8'h42);
        wait_pops(7, 10);
        k = pop_log[6];
        drive_at(k + 20);
        reset = 1'b1;
        @(posedge clock);
        #2;
        reset = 1'b0;
        @(negedge clock);
        #1;
        check("mrst_cycle", cyc, k + 21);
        check("mrst_tx", tx, 1'b1);
        check("mrst_busy", busy, 1'b0);
        check("mrst_fcount", frame_count, 16'd0);
        wait_pops(8, 10);
        check("mrst_repop", pop_log[7], k + 21);
        goto_cycle(pop_log[7] + P + 1);
        check("mrst_fcount_after", frame_count, 16'd1);
        check("mrst_busy_after", busy, 1'b0);
        check("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
